tff_count_ctrl: RTL and testbench

TFF_COUNT_CTRL -- requirements
Module: tff_count_ctrl

---
 rtl/tffc_pkg.sv | 20 ++
 rtl/tff_count_ctrl_if.sv | 36 +++
 rtl/tffc_bank.sv | 38 +++
 rtl/tff_count_ctrl.sv | 150 +++++++++++++++
 tb/tb_tff_count_ctrl.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/tffc_pkg.sv
// -----------------------------------------------------------------------------
// tffc_pkg
// Shared definitions for the tff_count_ctrl block: the default counter width
// and the controller state encoding.
// -----------------------------------------------------------------------------
package tffc_pkg;

   // Default width of the count register and the limit.
   localparam int TFFC_WIDTH = 8;

   // Controller states.
   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_RUN,
      ST_PAUSE,
      ST_DONE
   } state_e;

endpackage : tffc_pkg

// File: rtl/tff_count_ctrl_if.sv
// -----------------------------------------------------------------------------
// tff_count_ctrl_if
// Control/status bundle of the tff_count_ctrl block.
//   start : one-cycle request that begins a counting run
//   stop  : level request, pauses the run while high
//   limit : terminal value, sampled when start is accepted
//   dir   : count direction (1 = down), only when TFFC_DOWN_EN is defined
//   count : current value of the T flip-flop bank
//   busy  : high while the run is counting or paused
//   done  : one-cycle completion pulse
// master drives the requests; slave is the counter controller.
// Optional feature macro: TFFC_DOWN_EN
// -----------------------------------------------------------------------------
interface tff_count_ctrl_if
   import tffc_pkg::*;
#(
   parameter int WIDTH = TFFC_WIDTH
);

   logic             start;
   logic             stop;
   logic [WIDTH-1:0] limit;
   logic [WIDTH-1:0] count;
   logic             busy;
   logic             done;
`ifdef TFFC_DOWN_EN
   logic             dir;

   modport master (output start, stop, limit, dir, input count, busy, done);
   modport slave  (input start, stop, limit, dir, output count, busy, done);
`else
   modport master (output start, stop, limit, input count, busy, done);
   modport slave  (input start, stop, limit, output count, busy, done);
`endif

endinterface : tff_count_ctrl_if

// File: rtl/tffc_bank.sv
// -----------------------------------------------------------------------------
// tffc_bank
// WIDTH independent T flip-flops sharing one clock.
//   clk   : clock, all bits update on its rising edge
//   clr   : synchronous active-high clear, every bit goes to 0
//   t_vec : per-bit toggle enable
//   q     : current flip-flop values
// -----------------------------------------------------------------------------
module tffc_bank
   import tffc_pkg::*;
#(
   parameter int WIDTH = TFFC_WIDTH
) (
   input  logic             clk,
   input  logic             clr,
   input  logic [WIDTH-1:0] t_vec,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] q_q;
   logic [WIDTH-1:0] q_d;

   // A set toggle-enable bit inverts that bit; a clear one holds it.
   assign q_d = q_q ^ t_vec;

   // NOTE: clr is sampled on the clock edge, so it lives inside the clocked
   // branch rather than in the sensitivity list.
   always_ff @(posedge clk) begin
      if (clr) begin
         q_q <= '0;
      end else begin
         q_q <= q_d;
      end
   end

   assign q = q_q;

endmodule : tffc_bank

// File: rtl/tff_count_ctrl.sv
// -----------------------------------------------------------------------------
// tff_count_ctrl
// Counter controller built around a bank of T flip-flops. A start request
// captures the limit, loads the initial value through toggle enables and then
// steps the count once per cycle until it reaches the terminal value, pausing
// while stop is held. done pulses for one cycle at completion.
//   clk : clock (rising edge)
//   clr : synchronous active-high reset, aborts any run without a done pulse
//   bus : tff_count_ctrl_if.slave (start, stop, limit, [dir], count, busy, done)
// Optional feature macro: TFFC_DOWN_EN adds bus.dir; with dir=1 at start the
// run counts down from the limit to zero.
// -----------------------------------------------------------------------------
module tff_count_ctrl
   import tffc_pkg::*;
#(
   parameter int WIDTH = TFFC_WIDTH
) (
   input  logic             clk,
   input  logic             clr,
   tff_count_ctrl_if.slave  bus
);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] lim_q, lim_d;
   logic [WIDTH-1:0] count;
   logic [WIDTH-1:0] t_vec;
   logic [WIDTH-1:0] step_vec;
   logic [WIDTH-1:0] init_val;
   logic [WIDTH-1:0] term_val;
   logic             down;
   logic             at_term;

`ifdef TFFC_DOWN_EN
   logic dir_q, dir_d;
   assign down = dir_q;
`else
   assign down = 1'b0;
`endif

   // The controller only ever toggles bits; the bank owns the count value.
   tffc_bank #(.WIDTH(WIDTH)) u_bank (
      .clk   (clk),
      .clr   (clr),
      .t_vec (t_vec),
      .q     (count)
   );

   // Up: the run starts at 0 and ends at the limit. Down: the reverse.
   assign init_val = down ? lim_q : '0;
   assign term_val = down ? '0    : lim_q;
   assign at_term  = (count == term_val);

   // Ripple toggle chain: bit i toggles when every lower bit is 1 (up) or
   // every lower bit is 0 (down), which is exactly +1 / -1.
   always_comb begin
      step_vec    = '0;
      step_vec[0] = 1'b1;
      for (int i = 1; i < WIDTH; i++) begin
         step_vec[i] = step_vec[i-1] & (count[i-1] ^ down);
      end
   end

   // State register.
   // NOTE: clocked state uses non-blocking assignments so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (clr) begin
         state_q <= ST_IDLE;
         lim_q   <= '0;
`ifdef TFFC_DOWN_EN
         dir_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         lim_q   <= lim_d;
`ifdef TFFC_DOWN_EN
         dir_q   <= dir_d;
`endif
      end
   end

   // Next-state logic.
   // NOTE: every signal gets a hold default first so no path through the case
   // leaves it unassigned, which would otherwise infer a latch.
   always_comb begin
      state_d = state_q;
      lim_d   = lim_q;
`ifdef TFFC_DOWN_EN
      dir_d   = dir_q;
`endif
      unique case (state_q)
         ST_IDLE: begin
            if (bus.start) begin
               lim_d   = bus.limit;
`ifdef TFFC_DOWN_EN
               dir_d   = bus.dir;
`endif
               state_d = ST_LOAD;
            end
         end
         ST_LOAD:  state_d = ST_RUN;
         ST_RUN: begin
            // Terminal detection wins over a simultaneous stop.
            if (at_term) begin
               state_d = ST_DONE;
            end else if (bus.stop) begin
               state_d = ST_PAUSE;
            end
         end
         ST_PAUSE: begin
            if (!bus.stop) begin
               state_d = ST_RUN;
            end
         end
         ST_DONE:  state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   // Output logic.
   always_comb begin
      t_vec    = '0;
      bus.busy = 1'b0;
      bus.done = 1'b0;
      unique case (state_q)
         // Toggling exactly the differing bits lands the bank on init_val.
         ST_LOAD:  t_vec = count ^ init_val;
         ST_RUN: begin
            bus.busy = 1'b1;
            if (!at_term && !bus.stop) begin
               t_vec = step_vec;
            end
         end
         ST_PAUSE: begin
            bus.busy = 1'b1;
            // Pause is only entered below the terminal value, so the first
            // cycle with stop released already counts: the run is delayed by
            // exactly the number of stop cycles.
            if (!bus.stop) begin
               t_vec = step_vec;
            end
         end
         ST_DONE:  bus.done = 1'b1;
         default:  t_vec = '0;
      endcase
   end

   assign bus.count = count;

endmodule : tff_count_ctrl

// File: tb/tb_tff_count_ctrl.sv
// -----------------------------------------------------------------------------
// tb_tff_count_ctrl
// Self-checking bench for tff_count_ctrl: a vector table for the basic run,
// hand-written multi-cycle sequences for the corner cases, and a randomized
// phase compared against a behavioural model of the counting rules.
// Optional feature macro: TFFC_DOWN_EN (enables the down-count sequence).
// -----------------------------------------------------------------------------
module tb_tff_count_ctrl;
   import tffc_pkg::*;

   localparam int W   = 8;
   localparam int MOD = 1 << W;

   logic clk = 1'b0;
   logic clr;

   always #5 clk = ~clk;

   tff_count_ctrl_if #(.WIDTH(W)) bus ();

   tff_count_ctrl #(.WIDTH(W)) dut (
      .clk (clk),
      .clr (clr),
      .bus (bus.slave)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // A run is "loading" for one cycle, then "active" (busy) until the count
   // sits at its terminal value, then "done" for one cycle. While active the
   // count moves one step on each cycle stop is low.
   int m_cnt, m_lim;
   bit m_dir, m_active, m_load, m_done;

   function automatic void model_step(bit c, bit s, bit st, int lim, bit d);
      int term;
      bit idle, done_n;
      if (c) begin
         m_cnt = 0; m_lim = 0; m_dir = 0;
         m_active = 0; m_load = 0; m_done = 0;
         return;
      end
      term   = m_dir ? 0 : m_lim;
      idle   = !m_active && !m_load && !m_done;
      done_n = m_active && (m_cnt == term);
      if (m_load) begin
         m_cnt    = m_dir ? m_lim : 0;
         m_active = 1;
         m_load   = 0;
      end else if (m_active) begin
         if (m_cnt == term)  m_active = 0;
         else if (!st)       m_cnt = m_dir ? (m_cnt + MOD - 1) % MOD : (m_cnt + 1) % MOD;
      end
      m_done = done_n;
      if (idle && s) begin
         m_lim  = lim;
`ifdef TFFC_DOWN_EN
         m_dir  = d;
`else
         m_dir  = 0;
         if (d) m_dir = 0;
`endif
         m_load = 1;
      end
   endfunction

   // One clock cycle: drive inputs, advance the model, sample 1 ns after the edge.
   task automatic step(input bit c, input bit s, input bit st, input int lim,
                       input bit d, input bit chk);
      clr       = c;
      bus.start = s;
      bus.stop  = st;
      bus.limit = lim[W-1:0];
`ifdef TFFC_DOWN_EN
      bus.dir   = d;
`endif
      model_step(c, s, st, lim, d);
      @(posedge clk);
      #1;
      if (chk) begin
         check("model_count", bus.count, m_cnt);
         check("model_busy",  bus.busy,  m_active);
         check("model_done",  bus.done,  m_done);
      end
   endtask

   task automatic idle_step(input bit chk);
      step(0, 0, 0, 0, 0, chk);
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      bit         clr;
      bit         start;
      bit         stop;
      logic [7:0] limit;
      logic [7:0] e_count;
      bit         e_busy;
      bit         e_done;
   } vec_t;

   vec_t tbl[20];

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int k;
      clr = 1'b1; bus.start = 0; bus.stop = 0; bus.limit = '0;
`ifdef TFFC_DOWN_EN
      bus.dir = 0;
`endif
      //        clr st stp lim  cnt busy done
      tbl[0]  = '{1, 0, 0,   0,   0, 0, 0}; // reset state
      tbl[1]  = '{0, 1, 0,   5,   0, 0, 0}; // start, LOAD
      tbl[2]  = '{0, 0, 0,   5,   0, 1, 0};
      tbl[3]  = '{0, 0, 0,   1,   1, 1, 0}; // limit change ignored
      tbl[4]  = '{0, 1, 0,   9,   2, 1, 0}; // start ignored while busy
      tbl[5]  = '{0, 0, 0,   0,   3, 1, 0};
      tbl[6]  = '{0, 0, 0,   0,   4, 1, 0};
      tbl[7]  = '{0, 0, 0,   0,   5, 1, 0};
      tbl[8]  = '{0, 0, 0,   0,   5, 0, 1}; // done at N+8
      tbl[9]  = '{0, 0, 0,   0,   5, 0, 0}; // count holds in IDLE
      tbl[10] = '{0, 1, 0,   2,   5, 0, 0}; // LOAD, count holds until load edge
      tbl[11] = '{0, 0, 0,   0,   0, 1, 0};
      tbl[12] = '{0, 0, 0,   0,   1, 1, 0};
      tbl[13] = '{0, 0, 0,   0,   2, 1, 0};
      tbl[14] = '{0, 0, 0,   0,   2, 0, 1};
      tbl[15] = '{0, 0, 0,   0,   2, 0, 0};
      tbl[16] = '{0, 1, 0,   0,   2, 0, 0}; // zero limit
      tbl[17] = '{0, 0, 0,   0,   0, 1, 0}; // single RUN cycle
      tbl[18] = '{0, 0, 0,   0,   0, 0, 1};
      tbl[19] = '{0, 0, 0,   0,   0, 0, 0};

      for (int i = 0; i < 20; i++) begin
         step(tbl[i].clr, tbl[i].start, tbl[i].stop, int'(tbl[i].limit), 0, 0);
         check($sformatf("tbl%0d_count", i), bus.count, tbl[i].e_count);
         check($sformatf("tbl%0d_busy",  i), bus.busy,  tbl[i].e_busy);
         check($sformatf("tbl%0d_done",  i), bus.done,  tbl[i].e_done);
      end

      // ---- pause and resume: limit 10, stop for 3 cycles at count 4 ----
      step(0, 1, 0, 10, 0, 1); k = 1;
      repeat (5) begin idle_step(1); k++; end
      check("pause_pre_count", bus.count, 4);
      repeat (3) begin
         step(0, 0, 1, 0, 0, 1); k++;
         check("pause_hold_count", bus.count, 4);
         check("pause_hold_busy",  bus.busy,  1);
      end
      idle_step(1); k++;
      check("pause_resume_count", bus.count, 5);
      while (!bus.done && k < 40) begin idle_step(1); k++; end
      check("pause_done_cycle", k, 16);
      check("pause_done_count", bus.count, 10);
      idle_step(1);

      // ---- stop together with terminal: DONE, not PAUSE ----
      step(0, 1, 0, 3, 0, 1);
      repeat (4) idle_step(1);
      check("stopterm_at_lim", bus.count, 3);
      step(0, 0, 1, 0, 0, 1);
      check("stopterm_done", bus.done, 1);
      check("stopterm_busy", bus.busy, 0);
      step(0, 0, 1, 0, 0, 1);
      check("stopterm_idle_busy", bus.busy, 0);
      check("stopterm_idle_done", bus.done, 0);

      // ---- clr mid-run with simultaneous start ----
      step(0, 1, 0, 200, 0, 1);
      repeat (4) idle_step(1);
      check("clr_pre_count", bus.count, 3);
      step(1, 1, 0, 7, 0, 1);
      check("clr_count", bus.count, 0);
      check("clr_busy",  bus.busy,  0);
      check("clr_done",  bus.done,  0);
      repeat (3) begin
         idle_step(1);
         check("clr_after_busy",  bus.busy,  0);
         check("clr_after_done",  bus.done,  0);
         check("clr_after_count", bus.count, 0);
      end

      // ---- full-range run: limit 255, no wrap ----
      step(0, 1, 0, 255, 0, 1); k = 1;
      while (!bus.done && k < 400) begin idle_step(1); k++; end
      check("wrap_done_cycle", k, 258);
      check("wrap_done_count", bus.count, 255);
      idle_step(1);
      check("wrap_hold_count", bus.count, 255);
      check("wrap_hold_done",  bus.done,  0);

`ifdef TFFC_DOWN_EN
      // ---- down mode: limit 3 -> 3,2,1,0 then done ----
      step(0, 1, 0, 3, 1, 1);
      for (int j = 0; j < 4; j++) begin
         idle_step(1);
         check("down_count", bus.count, 3 - j);
         check("down_busy",  bus.busy,  1);
      end
      idle_step(1);
      check("down_done",       bus.done,  1);
      check("down_done_count", bus.count, 0);
      idle_step(1);
`endif

      // ---- randomized traffic against the model ----
      for (int n = 0; n < 3000; n++) begin
         bit r_clr, r_start, r_stop, r_dir;
         int r_lim;
         r_clr   = ($urandom % 64) == 0;
         r_start = ($urandom % 4) == 0;
         r_stop  = ($urandom % 4) == 0;
         r_dir   = $urandom % 2;
         r_lim   = (($urandom % 8) == 0) ? int'($urandom % MOD) : int'($urandom % 12);
         step(r_clr, r_start, r_stop, r_lim, r_dir, 1);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule : tb_tff_count_ctrl
